// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch and jump resolution.
// Resolves taken branches and jumps from the ALU flags and emits a one-cycle
// redirect (or a misaligned pulse). Wrong-path instructions in the redirect
// shadow are dropped. The resolved instruction is registered for the memory
// stage behind a valid/ready handshake.
module ex_mem_stage #(
   parameter int width_p          = 32,
   parameter int reg_addr_width_p = 5
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [width_p-1:0]          pc_i,
   input  logic [width_p-1:0]          imm_i,
   input  logic [width_p-1:0]          alu_result_i,
   input  logic                        alu_zero_i,
   input  logic                        is_branch_i,
   input  logic [2:0]                  br_funct3_i,
   input  logic                        is_jal_i,
   input  logic                        is_jalr_i,
   input  logic [reg_addr_width_p-1:0] rd_addr_i,
   input  logic                        rd_we_i,
   input  logic [width_p-1:0]          store_data_i,
   input  logic                        mem_re_i,
   input  logic                        mem_we_i,
   input  logic [1:0]                  mem_size_i,
   input  logic                        flush_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [width_p-1:0]          result_o,
   output logic [width_p-1:0]          store_data_o,
   output logic [reg_addr_width_p-1:0] rd_addr_o,
   output logic                        rd_we_o,
   output logic                        mem_re_o,
   output logic                        mem_we_o,
   output logic [1:0]                  mem_size_o,
   output logic                        redirect_o,
   output logic [width_p-1:0]          redirect_pc_o,
   output logic                        misaligned_o
);

   logic               br_taken;
   logic               is_jump;
   logic               take;
   logic               bad_target;
   logic               capture;
   logic [width_p-1:0] target;
   logic [width_p-1:0] link_pc;

   // Branch condition from the zero flag; decode picked SUB/SLT/SLTU to match.
   always_comb begin
      br_taken = 1'b0;
      case (br_funct3_i)
         3'b000:  br_taken = alu_zero_i;   // BEQ
         3'b001:  br_taken = !alu_zero_i;  // BNE
         3'b100:  br_taken = !alu_zero_i;  // BLT  (SLT result 1)
         3'b101:  br_taken = alu_zero_i;   // BGE  (SLT result 0)
         3'b110:  br_taken = !alu_zero_i;  // BLTU (SLTU result 1)
         3'b111:  br_taken = alu_zero_i;   // BGEU (SLTU result 0)
         default: br_taken = 1'b0;
      endcase
   end

   assign is_jump    = is_jal_i || is_jalr_i;
   assign take       = is_jump || (is_branch_i && br_taken);
   assign target     = is_jalr_i ? {alu_result_i[width_p-1:1], 1'b0}
                                 : pc_i + imm_i;
   assign link_pc    = pc_i + width_p'(4);
   assign bad_target = take && (target[1:0] != 2'b00);

   // During a redirect the incoming instruction is wrong-path: always consume it.
   assign ready_o = redirect_o || !valid_o || ready_i;
   assign capture = valid_i && !flush_i && !redirect_o && (!valid_o || ready_i);

   // Control side: valid, redirect and misaligned pulses.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_o      <= 1'b0;
         redirect_o   <= 1'b0;
         misaligned_o <= 1'b0;
      end else begin
         redirect_o   <= capture && take && !bad_target;
         misaligned_o <= capture && bad_target;
         if (capture)
            valid_o <= 1'b1;
         else if (flush_i || ready_i)
            valid_o <= 1'b0;
      end
   end

   // Payload register: loads only on capture, so it holds while stalled.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         result_o      <= '0;
         store_data_o  <= '0;
         rd_addr_o     <= '0;
         rd_we_o       <= 1'b0;
         mem_re_o      <= 1'b0;
         mem_we_o      <= 1'b0;
         mem_size_o    <= '0;
         redirect_pc_o <= '0;
      end else if (capture) begin
         result_o      <= is_jump ? link_pc : alu_result_i;
         store_data_o  <= store_data_i;
         rd_addr_o     <= rd_addr_i;
         rd_we_o       <= rd_we_i && !bad_target;
         mem_re_o      <= mem_re_i;
         mem_we_o      <= mem_we_i;
         mem_size_o    <= mem_size_i;
         redirect_pc_o <= target;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed bench for ex_mem_stage with a transaction-level
// reference model compared every cycle, plus literal checks on key scenarios.
module tb_ex_mem_stage;

   logic        clk_i = 1'b0;
   logic        reset_i, valid_i, ready_o, alu_zero_i, is_branch_i;
   logic        is_jal_i, is_jalr_i, rd_we_i, mem_re_i, mem_we_i, flush_i;
   logic        valid_o, ready_i, rd_we_o, mem_re_o, mem_we_o;
   logic        redirect_o, misaligned_o;
   logic [31:0] pc_i, imm_i, alu_result_i, store_data_i;
   logic [31:0] result_o, store_data_o, redirect_pc_o;
   logic [2:0]  br_funct3_i;
   logic [4:0]  rd_addr_i, rd_addr_o;
   logic [1:0]  mem_size_i, mem_size_o;

   int tests = 0;
   int fails = 0;

   ex_mem_stage #(.width_p(32), .reg_addr_width_p(5)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
      .pc_i(pc_i), .imm_i(imm_i), .alu_result_i(alu_result_i),
      .alu_zero_i(alu_zero_i), .is_branch_i(is_branch_i),
      .br_funct3_i(br_funct3_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
      .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .store_data_i(store_data_i),
      .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
      .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
      .result_o(result_o), .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
      .rd_we_o(rd_we_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
      .mem_size_o(mem_size_o), .redirect_o(redirect_o),
      .redirect_pc_o(redirect_pc_o), .misaligned_o(misaligned_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        valid;
      logic [31:0] result, store_data;
      logic [4:0]  rd_addr;
      logic        rd_we, mem_re, mem_we;
      logic [1:0]  mem_size;
   } slot_t;

   slot_t       m_slot;
   logic        m_redir = 1'b0, m_mis = 1'b0, m_ok = 1'b0;
   logic [31:0] m_rpc;

   function automatic logic spec_taken(input logic [2:0] f3, input logic zero);
      case (f3)
         3'd0: return zero;    // BEQ
         3'd1: return !zero;   // BNE
         3'd4: return !zero;   // BLT
         3'd5: return zero;    // BGE
         3'd6: return !zero;   // BLTU
         3'd7: return zero;    // BGEU
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk_i) begin
      logic        accepted, jump, take, bad;
      logic [31:0] tgt;
      if (reset_i) begin
         m_slot  = '{1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};
         m_redir = 1'b0;
         m_mis   = 1'b0;
         m_rpc   = 32'd0;
         m_ok    = 1'b1;
      end else if (m_ok) begin
         // Instruction enters only if not shadowed, not killed, and there is room.
         accepted = valid_i && !flush_i && !m_redir && (!m_slot.valid || ready_i);
         jump = is_jal_i || is_jalr_i;
         take = jump || (is_branch_i && spec_taken(br_funct3_i, alu_zero_i));
         tgt  = is_jalr_i ? (alu_result_i & 32'hFFFF_FFFE) : (pc_i + imm_i);
         bad  = take && (tgt % 4 != 0);
         m_redir = accepted && take && !bad;
         m_mis   = accepted && bad;
         if (accepted) begin
            m_rpc  = tgt;
            m_slot = '{1'b1, jump ? pc_i + 32'd4 : alu_result_i, store_data_i,
                       rd_addr_i, rd_we_i && !bad, mem_re_i, mem_we_i, mem_size_i};
         end else if (flush_i || ready_i) begin
            m_slot.valid = 1'b0;
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk_i) begin
      if (m_ok && !reset_i) begin
         chk("m.valid_o", valid_o, m_slot.valid);
         chk("m.redirect_o", redirect_o, m_redir);
         chk("m.misaligned_o", misaligned_o, m_mis);
         chk("m.ready_o", ready_o, m_redir || !m_slot.valid || ready_i);
         if (m_redir) chk("m.redirect_pc_o", redirect_pc_o, m_rpc);
         if (m_slot.valid) begin
            chk("m.result_o", result_o, m_slot.result);
            chk("m.store_data_o", store_data_o, m_slot.store_data);
            chk("m.rd_addr_o", rd_addr_o, m_slot.rd_addr);
            chk("m.rd_we_o", rd_we_o, m_slot.rd_we);
            chk("m.mem_re_o", mem_re_o, m_slot.mem_re);
            chk("m.mem_we_o", mem_we_o, m_slot.mem_we);
            chk("m.mem_size_o", mem_size_o, m_slot.mem_size);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      valid_i = 0; is_branch_i = 0; is_jal_i = 0; is_jalr_i = 0; flush_i = 0;
      alu_zero_i = 0; br_funct3_i = 0; rd_we_i = 0; mem_re_i = 0; mem_we_i = 0;
      mem_size_i = 0; rd_addr_i = 0; pc_i = 0; imm_i = 0; alu_result_i = 0;
      store_data_i = 0;
   endtask

   task automatic alu_op(input logic [31:0] res, input logic [4:0] rd);
      idle();
      valid_i = 1; alu_result_i = res; rd_addr_i = rd; rd_we_i = 1;
      store_data_i = res ^ 32'h5A5A_0000; mem_size_i = 2'd2;
   endtask

   task automatic branch(input logic [2:0] f3, input logic zero,
                         input logic [31:0] pc, input logic [31:0] imm);
      idle();
      valid_i = 1; is_branch_i = 1; br_funct3_i = f3; alu_zero_i = zero;
      alu_result_i = {31'd0, !zero}; pc_i = pc; imm_i = imm;
   endtask

   int pulses;
   logic [2:0] f3s [8] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};

   initial begin
      idle();
      ready_i = 1; reset_i = 1;
      step(); step();
      chk("reset valid_o", valid_o, 0);
      chk("reset redirect_o", redirect_o, 0);
      chk("reset result_o", result_o, 0);
      reset_i = 0;

      // Reset while stalled.
      alu_op(32'h1234_5678, 5'd7); ready_i = 0;
      step();
      chk("stall valid_o", valid_o, 1);
      idle(); reset_i = 1;
      step();
      chk("rst-stall valid_o", valid_o, 0);
      chk("rst-stall result_o", result_o, 0);
      chk("rst-stall rd_addr_o", rd_addr_o, 0);
      chk("rst-stall redirect_o", redirect_o, 0);
      reset_i = 0; ready_i = 1;
      step();

      // BEQ taken, then a wrong-path instruction in the shadow.
      branch(3'd0, 1'b1, 32'h100, 32'h20);
      step();
      chk("beq redirect_o", redirect_o, 1);
      chk("beq redirect_pc_o", redirect_pc_o, 32'h120);
      alu_op(32'hDEAD, 5'd9);
      #1 chk("shadow ready_o", ready_o, 1);
      step();
      chk("beq one pulse", redirect_o, 0);
      chk("shadow dropped", valid_o, 0);
      idle(); step();

      // BGEU not taken: SLTU result 1, zero 0.
      branch(3'd7, 1'b0, 32'h300, 32'h40);
      step();
      chk("bgeu redirect_o", redirect_o, 0);
      chk("bgeu valid_o", valid_o, 1);
      chk("bgeu rd_we_o", rd_we_o, 0);
      chk("bgeu result_o", result_o, 1);

      // JALR to a misaligned target with a wrapping link address.
      idle(); valid_i = 1; is_jalr_i = 1; alu_result_i = 32'h2003;
      pc_i = 32'hFFFF_FFFC; rd_we_i = 1; rd_addr_i = 5'd1;
      step();
      chk("jalr misaligned_o", misaligned_o, 1);
      chk("jalr redirect_o", redirect_o, 0);
      chk("jalr result_o", result_o, 32'h0);
      chk("jalr rd_we_o", rd_we_o, 0);
      idle(); step();
      chk("jalr mis one pulse", misaligned_o, 0);

      // Taken JAL held under back-pressure.
      idle(); valid_i = 1; is_jal_i = 1; pc_i = 32'h40; imm_i = 32'h100;
      rd_we_i = 1; rd_addr_i = 5'd3; ready_i = 0;
      step();
      pulses = int'(redirect_o);
      chk("jal redirect_pc_o", redirect_pc_o, 32'h140);
      chk("jal result_o", result_o, 32'h44);
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(redirect_o);
         chk("bp ready_o", ready_o, 0);
         chk("bp valid_o", valid_o, 1);
         chk("bp result_o", result_o, 32'h44);
      end
      chk("bp pulse count", pulses, 1);
      ready_i = 1;
      step();

      // Streaming with a flush on the third accept.
      alu_op(32'd1, 5'd1); step();
      chk("stream1", result_o, 32'd1);
      alu_op(32'd2, 5'd2); step();
      chk("stream2", result_o, 32'd2);
      chk("stream2 valid", valid_o, 1);
      alu_op(32'd3, 5'd3); flush_i = 1; step();
      chk("stream3 killed", valid_o, 0);
      alu_op(32'd4, 5'd4); step();
      chk("stream4 valid", valid_o, 1);
      chk("stream4", result_o, 32'd4);
      idle(); step();

      // All funct3 codes, both flag values, checked by the model.
      for (int i = 0; i < 8; i++) begin
         for (int z = 0; z < 2; z++) begin
            branch(f3s[i], z[0], 32'h200 + 32'(i * 16), 32'h8);
            step();
            idle(); step();
         end
      end
      branch(3'd1, 1'b0, 32'h500, 32'hFFFF_FFF0);
      step();
      chk("bne back target", redirect_pc_o, 32'h4F0);
      chk("bne back redirect", redirect_o, 1);
      idle(); step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
